// File: rtl/pipe_stage_elastic.sv
// Generic elastic pipeline latch: DEPTH register stages with valid/ready
// handshake, bubble collapsing, global stall/flush and an occupancy count.
module pipe_stage_elastic #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 1,
    parameter int ZERO_INVALID = 1
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         stall,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]             v_q, v_d;
    logic [DEPTH-1:0][DATA_W-1:0] d_q, d_d;
    logic [DEPTH-1:0]             rdy;
    logic                         rdy_acc;
    logic                         in_fire;

    // A stage is ready when it or any stage downstream of it is empty,
    // or the consumer takes the head; accumulated from the output end.
    always_comb begin
        rdy     = '0;
        rdy_acc = out_ready;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rdy_acc            = rdy_acc | !v_q[DEPTH-1-i];
            rdy[DEPTH-1-i]     = rdy_acc;
        end
    end

    always_comb begin
        in_ready  = rdy[0] & !stall & !flush & !RST;
        out_valid = v_q[DEPTH-1] & !stall & !flush;
        in_fire   = in_valid & in_ready;
        if ((ZERO_INVALID != 0) && !out_valid) begin
            out_data = '0;
        end else begin
            out_data = d_q[DEPTH-1];
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = '0;
            d_d = '0;
        end else if (!stall) begin
            if (rdy[0]) begin
                v_d[0] = in_fire;
                if (in_fire) begin
                    d_d[0] = in_data;
                end
            end
            for (int unsigned k = 1; k < DEPTH; k++) begin
                if (rdy[k]) begin
                    v_d[k] = v_q[k-1];
                    if (v_q[k-1]) begin
                        d_d[k] = d_q[k-1];
                    end
                end
            end
        end
    end

    always_comb begin
        count = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            count = count + CNT_W'(v_q[k]);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v_q <= '0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic (DEPTH=3) with an in-order scoreboard
// of accepted payloads checked against every output transfer.
module tb_pipe_stage_elastic;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        stall;
    logic        flush;
    logic [1:0]  count;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb[$];

    pipe_stage_elastic #(
        .DATA_W(32),
        .DEPTH(3),
        .ZERO_INVALID(1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .stall(stall),
        .flush(flush),
        .count(count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs at the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic iv, input logic [31:0] id, input logic ordy,
                         input logic st, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        #1;
    endtask

    // Scoreboard update for the current cycle, then advance to the next falling edge.
    task automatic tick();
        logic [31:0] exp_d;
        chk("occupancy", 32'(count), 32'(sb.size()));
        if (out_valid && out_ready) begin
            total++;
            assert (sb.size() != 0) else begin
                bad++;
                $error("FAIL sb_extra observed=%h expected=none", out_data);
            end
            if (sb.size() != 0) begin
                exp_d = sb.pop_front();
                chk("sb_data", out_data, exp_d);
            end
        end
        if (in_valid && in_ready) sb.push_back(in_data);
        if (flush) sb.delete();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        @(negedge CLK);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        RST = 1'b0;

        // 1: streaming, latency DEPTH
        drive(1, 32'h11, 1, 0, 0); chk("t1_in_ready", 32'(in_ready), 32'd1); tick();
        drive(1, 32'h22, 1, 0, 0); chk("t1_ov_b", 32'(out_valid), 32'd0); tick();
        drive(1, 32'h33, 1, 0, 0); chk("t1_ov_c", 32'(out_valid), 32'd0); tick();
        drive(0, 32'h0, 1, 0, 0);
        chk("t1_ov_first", 32'(out_valid), 32'd1);
        chk("t1_data0", out_data, 32'h11);
        chk("t1_count_peak", 32'(count), 32'd3);
        tick();
        drive(0, 32'h0, 1, 0, 0); chk("t1_data1", out_data, 32'h22); tick();
        drive(0, 32'h0, 1, 0, 0); chk("t1_data2", out_data, 32'h33); tick();
        drive(0, 32'h0, 1, 0, 0); chk("t1_drained", 32'(out_valid), 32'd0); tick();

        // 2: fill against backpressure, then simultaneous in/out fire
        drive(1, 32'h11, 0, 0, 0); tick();
        drive(1, 32'h22, 0, 0, 0); tick();
        drive(1, 32'h33, 0, 0, 0); tick();
        drive(1, 32'h44, 0, 0, 0);
        chk("t2_full_in_ready", 32'(in_ready), 32'd0);
        chk("t2_full_count", 32'(count), 32'd3);
        tick();
        drive(1, 32'h44, 1, 0, 0);
        chk("t2_pass_in_ready", 32'(in_ready), 32'd1);
        chk("t2_head", out_data, 32'h11);
        tick();
        drive(0, 32'h0, 1, 0, 0); chk("t2_count_same", 32'(count), 32'd3); tick();
        for (int i = 0; i < 3; i++) begin drive(0, 32'h0, 1, 0, 0); tick(); end
        drive(0, 32'h0, 1, 0, 0); chk("t2_empty", 32'(count), 32'd0); tick();

        // 3: bubble collapse under out_ready=0
        drive(1, 32'hA1, 0, 0, 0); tick();
        drive(0, 32'h0, 0, 0, 0); tick();
        drive(0, 32'h0, 0, 0, 0); tick();
        drive(1, 32'hA2, 0, 0, 0); tick();
        drive(0, 32'h0, 0, 0, 0); tick();
        drive(0, 32'h0, 0, 0, 0);
        chk("t3_count", 32'(count), 32'd2);
        chk("t3_in_ready", 32'(in_ready), 32'd1);
        chk("t3_head", out_data, 32'hA1);
        chk("t3_ov", 32'(out_valid), 32'd1);
        tick();

        // 4: flush a full pipe while offering a payload
        drive(1, 32'hB1, 0, 0, 0); tick();
        drive(1, 32'hDEAD, 0, 0, 1);
        chk("t4_fl_in_ready", 32'(in_ready), 32'd0);
        chk("t4_fl_out_valid", 32'(out_valid), 32'd0);
        chk("t4_fl_out_data", out_data, 32'd0);
        tick();
        drive(0, 32'h0, 1, 0, 0);
        chk("t4_count", 32'(count), 32'd0);
        chk("t4_out_data", out_data, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h0, 1, 0, 0); chk("t4_no_dead", 32'(out_valid), 32'd0); tick();
        end

        // 5: stall mid-stream, then stall+flush together
        drive(1, 32'h61, 1, 0, 0); tick();
        drive(1, 32'h62, 1, 0, 0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h63, 1, 1, 0);
            chk("t5_st_in_ready", 32'(in_ready), 32'd0);
            chk("t5_st_out_valid", 32'(out_valid), 32'd0);
            chk("t5_st_count", 32'(count), 32'd2);
            tick();
        end
        drive(1, 32'h63, 1, 0, 0); tick();
        drive(1, 32'h64, 1, 0, 0); tick();
        for (int i = 0; i < 4; i++) begin drive(0, 32'h0, 1, 0, 0); tick(); end
        drive(1, 32'h71, 0, 0, 0); tick();
        drive(1, 32'h72, 0, 1, 1);
        chk("t5_sf_in_ready", 32'(in_ready), 32'd0);
        chk("t5_sf_out_valid", 32'(out_valid), 32'd0);
        tick();
        drive(0, 32'h0, 1, 0, 0); chk("t5_sf_count", 32'(count), 32'd0); tick();

        // 6: asynchronous reset between edges
        drive(1, 32'h81, 0, 0, 0); tick();
        drive(1, 32'h82, 0, 0, 0); tick();
        drive(0, 32'h0, 0, 0, 0);
        chk("t6_pre_count", 32'(count), 32'd2);
        #1 RST = 1'b1;
        #1;
        chk("t6_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t6_rst_out_data", out_data, 32'd0);
        chk("t6_rst_count", 32'(count), 32'd0);
        sb.delete();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        drive(1, 32'h55, 1, 0, 0); chk("t6_accept", 32'(in_ready), 32'd1); tick();
        drive(0, 32'h0, 1, 0, 0); chk("t6_lat1", 32'(out_valid), 32'd0); tick();
        drive(0, 32'h0, 1, 0, 0); chk("t6_lat2", 32'(out_valid), 32'd0); tick();
        drive(0, 32'h0, 1, 0, 0);
        chk("t6_lat3", 32'(out_valid), 32'd1);
        chk("t6_data", out_data, 32'h55);
        tick();
        drive(0, 32'h0, 1, 0, 0); chk("t6_final_count", 32'(count), 32'd0); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
